// File: rtl/fetch_byte_server_pkg.sv
// Shared types and widths for the fetch byte server and its word FIFO.
package fetch_ser_pkg;

  localparam int unsigned WORD_W    = 16;
  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned GAP_CNT_W = 3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HI    = 3'd1,
    GAP_H = 3'd2,
    LO    = 3'd3,
    GAP_L = 3'd4
  } fsm_state_e;

endpackage

// File: rtl/fetch_byte_server_word_fifo.sv
// word_fifo: synchronous FIFO, power-of-two DEPTH, asynchronous active-high reset.
// Read data is the current head (show-ahead); pointers wrap modulo DEPTH.
module word_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  // Next pointer and occupancy; simultaneous push and pop leave the count unchanged.
  always_comb begin
    push_ok  = push && !full;
    pop_ok   = pop && !empty;
    wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop_ok  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
  end

  // Storage array write; contents need no reset since occupancy gates reads.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/fetch_byte_server.sv
// fetch_byte_server: buffers 16-bit instruction words and serialises them,
// high byte first, onto the instruction register's byte-wide load port.
// Optional statistics counters are enabled by FETCH_BYTE_SERVER_STATS_EN.
module fetch_byte_server
  import fetch_ser_pkg::*;
#(
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned GAP_CYCLES = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               word_valid,
  output logic               word_ready,
  input  logic [WORD_W-1:0]  word_in,
  output logic               ena,
  output logic [BYTE_W-1:0]  data,
  output logic               busy,
  output logic               done
`ifdef FETCH_BYTE_SERVER_STATS_EN
  ,
  output logic [15:0]        word_cnt,
  output logic [7:0]         ovf_cnt
`endif
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [GAP_CNT_W-1:0] GAP_LOAD =
    (GAP_CYCLES == 0) ? '0 : GAP_CNT_W'(GAP_CYCLES - 1);

  fsm_state_e            state_q, state_d;
  logic [GAP_CNT_W-1:0]  gap_q, gap_d;
  logic [WORD_W-1:0]     shadow_q, shadow_d;
  logic                  ena_q, ena_d;
  logic [BYTE_W-1:0]     data_q, data_d;
  logic                  done_q, done_d;
  logic                  busy_q, busy_d;
  logic                  ready_q, ready_d;

  logic                  push, pop;
  logic [WORD_W-1:0]     fifo_rdata;
  logic                  fifo_full, fifo_empty;
  logic [CNT_W-1:0]      fifo_count;
  logic [CNT_W-1:0]      cnt_nxt;

  assign push = word_valid && ready_q && !fifo_full;

  word_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WORD_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (word_in),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Next state, gap counter and pop request; a pop always coincides with entry to HI.
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          state_d = HI;
          pop     = 1'b1;
        end
      end
      HI: begin
        if (GAP_CYCLES > 0) begin
          state_d = GAP_H;
          gap_d   = GAP_LOAD;
        end else begin
          state_d = LO;
        end
      end
      GAP_H: begin
        if (gap_q == '0) begin
          state_d = LO;
        end else begin
          gap_d = gap_q - GAP_CNT_W'(1);
        end
      end
      LO: begin
        if (GAP_CYCLES > 0) begin
          state_d = GAP_L;
          gap_d   = GAP_LOAD;
        end else if (!fifo_empty) begin
          state_d = HI;
          pop     = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      GAP_L: begin
        if (gap_q != '0) begin
          gap_d = gap_q - GAP_CNT_W'(1);
        end else if (!fifo_empty) begin
          state_d = HI;
          pop     = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output next-values are derived from the next state so every output is a flop.
  always_comb begin
    shadow_d = pop ? fifo_rdata : shadow_q;
    cnt_nxt  = fifo_count + CNT_W'(push) - CNT_W'(pop);
    ena_d    = (state_d == HI) || (state_d == LO);
    done_d   = (state_d == LO);
    data_d   = data_q;
    if (state_d == HI) begin
      data_d = shadow_d[WORD_W-1:BYTE_W];
    end else if (state_d == LO) begin
      data_d = shadow_q[BYTE_W-1:0];
    end
    busy_d   = (state_d != IDLE) || (cnt_nxt != '0);
    ready_d  = (cnt_nxt != FULL_CNT);
  end

  // FSM, shadow word and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      gap_q    <= '0;
      shadow_q <= '0;
      ena_q    <= 1'b0;
      data_q   <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      gap_q    <= gap_d;
      shadow_q <= shadow_d;
      ena_q    <= ena_d;
      data_q   <= data_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      ready_q  <= ready_d;
    end
  end

  assign word_ready = ready_q;
  assign ena        = ena_q;
  assign data       = data_q;
  assign done       = done_q;
  assign busy       = busy_q;

`ifdef FETCH_BYTE_SERVER_STATS_EN
  logic [15:0] word_cnt_q;
  logic [7:0]  ovf_cnt_q;

  // Saturating counters: completed words (done pulses) and stalled-offer cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_cnt_q <= '0;
      ovf_cnt_q  <= '0;
    end else begin
      if (done_q && (word_cnt_q != '1)) begin
        word_cnt_q <= word_cnt_q + 16'd1;
      end
      if (word_valid && !ready_q && (ovf_cnt_q != '1)) begin
        ovf_cnt_q <= ovf_cnt_q + 8'd1;
      end
    end
  end

  assign word_cnt = word_cnt_q;
  assign ovf_cnt  = ovf_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_byte_server.sv
// Bench for fetch_byte_server: three instances with different DEPTH/GAP_CYCLES,
// a schedule-based reference model checked every cycle, and literal directed checks.
module tb_fetch_byte_server;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid [3];
  logic [15:0] win   [3];
  logic        ready [3];
  logic        ena   [3];
  logic [7:0]  data  [3];
  logic        busy  [3];
  logic        done  [3];
`ifdef FETCH_BYTE_SERVER_STATS_EN
  logic [15:0] wcnt  [3];
  logic [7:0]  ocnt  [3];
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_byte_server #(.DEPTH(2), .GAP_CYCLES(1)) u0 (
    .clk(clk), .reset(rst), .word_valid(valid[0]), .word_ready(ready[0]),
    .word_in(win[0]), .ena(ena[0]), .data(data[0]), .busy(busy[0]), .done(done[0])
`ifdef FETCH_BYTE_SERVER_STATS_EN
    , .word_cnt(wcnt[0]), .ovf_cnt(ocnt[0])
`endif
  );

  fetch_byte_server #(.DEPTH(2), .GAP_CYCLES(0)) u1 (
    .clk(clk), .reset(rst), .word_valid(valid[1]), .word_ready(ready[1]),
    .word_in(win[1]), .ena(ena[1]), .data(data[1]), .busy(busy[1]), .done(done[1])
`ifdef FETCH_BYTE_SERVER_STATS_EN
    , .word_cnt(wcnt[1]), .ovf_cnt(ocnt[1])
`endif
  );

  fetch_byte_server #(.DEPTH(4), .GAP_CYCLES(7)) u2 (
    .clk(clk), .reset(rst), .word_valid(valid[2]), .word_ready(ready[2]),
    .word_in(win[2]), .ena(ena[2]), .data(data[2]), .busy(busy[2]), .done(done[2])
`ifdef FETCH_BYTE_SERVER_STATS_EN
    , .word_cnt(wcnt[2]), .ovf_cnt(ocnt[2])
`endif
  );

  function automatic int gap_of(int i);
    return (i == 0) ? 1 : (i == 1) ? 0 : 7;
  endfunction

  function automatic int dep_of(int i);
    return (i == 2) ? 4 : 2;
  endfunction

  task automatic chk(input string nm, input int dut, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s dut%0d t=%0t got %h want %h", nm, dut, $time, got, want);
    end
  endtask

  // Reference model: each accepted word gets a start cycle s = max(accept+1, previous
  // word's end); the word occupies cycles s .. s+2+2G-1, strobing at s and s+1+G.
  int          cyc;
  int          last_end [3];
  int          ms [3][8];
  logic [15:0] mw [3][8];
  int          hd [3];
  int          tl [3];
  logic        e_ena [3], e_done [3], e_busy [3], e_ready [3];
  logic [7:0]  e_data [3];
`ifdef FETCH_BYTE_SERVER_STATS_EN
  int          e_wc [3], e_ovf [3];
`endif

  initial begin
    int n, s, p, g, cnt, off;
    logic [15:0] w;
    forever begin
      @(negedge clk);
      if (rst) begin
        cyc = 0;
        for (int i = 0; i < 3; i++) begin
          last_end[i] = 0; hd[i] = 0; tl[i] = 0;
          e_ena[i] = 1'b0; e_done[i] = 1'b0; e_busy[i] = 1'b0;
          e_ready[i] = 1'b1; e_data[i] = 8'h00;
`ifdef FETCH_BYTE_SERVER_STATS_EN
          e_wc[i] = 0; e_ovf[i] = 0;
`endif
        end
      end
      for (int i = 0; i < 3; i++) begin
        chk("ena", i, 16'(ena[i]), 16'(e_ena[i]));
        chk("data", i, 16'(data[i]), 16'(e_data[i]));
        chk("done", i, 16'(done[i]), 16'(e_done[i]));
        chk("busy", i, 16'(busy[i]), 16'(e_busy[i]));
        chk("ready", i, 16'(ready[i]), 16'(e_ready[i]));
`ifdef FETCH_BYTE_SERVER_STATS_EN
        chk("word_cnt", i, wcnt[i], 16'(e_wc[i]));
        chk("ovf_cnt", i, 16'(ocnt[i]), 16'(e_ovf[i]));
`endif
      end
      if (!rst) begin
        n = cyc + 1;
        for (int i = 0; i < 3; i++) begin
          g = gap_of(i);
          p = 2 + 2 * g;
`ifdef FETCH_BYTE_SERVER_STATS_EN
          if (e_done[i] && e_wc[i] < 65535) e_wc[i]++;
          if (valid[i] && !e_ready[i] && e_ovf[i] < 255) e_ovf[i]++;
`endif
          if (valid[i] && e_ready[i]) begin
            s = (n + 1 > last_end[i]) ? n + 1 : last_end[i];
            ms[i][tl[i] % 8] = s;
            mw[i][tl[i] % 8] = win[i];
            tl[i]++;
            last_end[i] = s + p;
          end
          cnt = 0;
          e_ena[i] = 1'b0; e_done[i] = 1'b0; e_busy[i] = 1'b0;
          for (int k = hd[i]; k < tl[i]; k++) begin
            s = ms[i][k % 8];
            w = mw[i][k % 8];
            if (s > n) cnt++;
            if (n < s + p) e_busy[i] = 1'b1;
            if (s <= n && n < s + p) begin
              off = n - s;
              if (off == 0 || off == 1 + g) e_ena[i] = 1'b1;
              if (off == 1 + g) e_done[i] = 1'b1;
              e_data[i] = (off < 1 + g) ? w[15:8] : w[7:0];
            end
          end
          while (hd[i] < tl[i] && n >= ms[i][hd[i] % 8] + p) hd[i]++;
          e_ready[i] = (cnt < dep_of(i));
        end
        cyc = n;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic        h_ena  [16];
  logic        h_done [16];
  logic [7:0]  h_data [16];
  logic [7:0]  exp_b  [6];
  logic [15:0] wl     [4];
  logic [7:0]  got_b  [8];

  initial begin
    int first, k, nb, noena;
    logic r, saw_nr;
    logic rdy [3];
    int pct;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin valid[i] = 1'b0; win[i] = 16'h0000; end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst ready", 0, 16'(ready[0]), 16'h1);
    chk("rst data", 0, 16'(data[0]), 16'h00);
    tick();

    // Single word, GAP_CYCLES=1
    valid[0] = 1'b1; win[0] = 16'h1234;
    tick();
    valid[0] = 1'b0;
    chk("A busy N", 0, 16'(busy[0]), 16'h1);
    chk("A ena N", 0, 16'(ena[0]), 16'h0);
    tick();
    chk("A ena N+1", 0, 16'(ena[0]), 16'h1);
    chk("A data N+1", 0, 16'(data[0]), 16'h12);
    tick();
    chk("A ena N+2", 0, 16'(ena[0]), 16'h0);
    chk("A data N+2", 0, 16'(data[0]), 16'h12);
    tick();
    chk("A ena N+3", 0, 16'(ena[0]), 16'h1);
    chk("A data N+3", 0, 16'(data[0]), 16'h34);
    chk("A done N+3", 0, 16'(done[0]), 16'h1);
    tick();
    chk("A busy N+4", 0, 16'(busy[0]), 16'h1);
    chk("A done N+4", 0, 16'(done[0]), 16'h0);
    tick();
    chk("A busy N+5", 0, 16'(busy[0]), 16'h0);
    tick();

    // Back-to-back, GAP_CYCLES=0
    wl[0] = 16'hE001; wl[1] = 16'h2FFE; wl[2] = 16'h7ABC;
    exp_b[0] = 8'hE0; exp_b[1] = 8'h01; exp_b[2] = 8'h2F;
    exp_b[3] = 8'hFE; exp_b[4] = 8'h7A; exp_b[5] = 8'hBC;
    k = 0; valid[1] = 1'b1; win[1] = wl[0];
    for (int c = 0; c < 12; c++) begin
      r = ready[1];
      tick();
      if (valid[1] && r) begin
        k++;
        if (k < 3) win[1] = wl[k]; else valid[1] = 1'b0;
      end
      h_ena[c] = ena[1]; h_data[c] = data[1]; h_done[c] = done[1];
    end
    first = -1;
    for (int c = 11; c >= 0; c--) if (h_ena[c]) first = c;
    chk("B strobe seen", 1, 16'(first >= 0 && first + 6 < 12), 16'h1);
    if (first >= 0 && first + 6 < 12) begin
      for (int j = 0; j < 6; j++) begin
        chk("B ena run", 1, 16'(h_ena[first + j]), 16'h1);
        chk("B byte", 1, 16'(h_data[first + j]), 16'(exp_b[j]));
        chk("B done", 1, 16'(h_done[first + j]), 16'(j % 2 == 1));
      end
      chk("B ena after", 1, 16'(h_ena[first + 6]), 16'h0);
    end
    repeat (4) tick();

    // Maximum gap, GAP_CYCLES=7
    valid[2] = 1'b1; win[2] = 16'hFF00;
    for (int c = 0; c < 14; c++) begin
      tick();
      valid[2] = 1'b0;
      h_ena[c] = ena[2]; h_data[c] = data[2]; h_done[c] = done[2];
    end
    first = -1;
    for (int c = 13; c >= 0; c--) if (h_ena[c]) first = c;
    chk("C strobe seen", 2, 16'(first >= 0 && first + 8 < 14), 16'h1);
    if (first >= 0 && first + 8 < 14) begin
      chk("C hi byte", 2, 16'(h_data[first]), 16'hFF);
      for (int j = 1; j <= 7; j++) begin
        chk("C gap ena", 2, 16'(h_ena[first + j]), 16'h0);
        chk("C gap data", 2, 16'(h_data[first + j]), 16'hFF);
      end
      chk("C lo ena", 2, 16'(h_ena[first + 8]), 16'h1);
      chk("C lo byte", 2, 16'(h_data[first + 8]), 16'h00);
      chk("C lo done", 2, 16'(h_done[first + 8]), 16'h1);
    end
    repeat (10) tick();

    // Backpressure, DEPTH=2, GAP_CYCLES=1
    wl[0] = 16'hC0DE; wl[1] = 16'h0BAD; wl[2] = 16'hF00D; wl[3] = 16'h5EED;
    k = 0; nb = 0; saw_nr = 1'b0; valid[0] = 1'b1; win[0] = wl[0];
    for (int c = 0; c < 40; c++) begin
      r = ready[0];
      if (valid[0] && !r) saw_nr = 1'b1;
      tick();
      if (valid[0] && r) begin
        k++;
        if (k < 4) win[0] = wl[k]; else valid[0] = 1'b0;
      end
      if (ena[0]) begin
        if (nb < 8) got_b[nb] = data[0];
        nb++;
      end
    end
    chk("D ready dropped", 0, 16'(saw_nr), 16'h1);
    chk("D byte count", 0, 16'(nb), 16'd8);
    for (int j = 0; j < 8 && j < nb; j++) begin
      chk("D byte order", 0, 16'(got_b[j]), (j % 2 == 0) ? 16'(wl[j / 2][15:8]) : 16'(wl[j / 2][7:0]));
    end

    // Reset mid-word in GAP_H
    valid[0] = 1'b1; win[0] = 16'hA5C3;
    tick();
    valid[0] = 1'b0;
    tick();
    tick();
    chk("E in gap ena", 0, 16'(ena[0]), 16'h0);
    chk("E in gap data", 0, 16'(data[0]), 16'hA5);
    #2 rst = 1'b1;
    #1;
    chk("E rst ena", 0, 16'(ena[0]), 16'h0);
    chk("E rst data", 0, 16'(data[0]), 16'h00);
    chk("E rst ready", 0, 16'(ready[0]), 16'h1);
    chk("E rst busy", 0, 16'(busy[0]), 16'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    noena = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (ena[0]) noena++;
    end
    chk("E no resume", 0, 16'(noena), 16'h0);

    // Randomised traffic on all instances, with one reset mid-run
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < 3; i++) rdy[i] = ready[i];
      tick();
      if (c == 1000) rst = 1'b1;
      if (c == 1003) rst = 1'b0;
      pct = ((c / 250) % 2 == 1) ? 95 : 35;
      for (int i = 0; i < 3; i++) begin
        if (!valid[i] || rdy[i]) begin
          valid[i] = ($urandom_range(99) < pct);
          win[i]   = 16'($urandom);
        end
      end
    end
    for (int i = 0; i < 3; i++) valid[i] = 1'b0;
    repeat (40) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_byte_server.md
Name: fetch_byte_server

Overview:
- Memory-side writer for the instruction register's byte-wide load port.
- Accepts 16-bit instruction words (opcode[15:13] + address[12:0]) over a valid/ready handshake and buffers them in a small FIFO.
- Serialises each word onto an 8-bit data bus, high byte first, with a one-cycle ena strobe per byte.
- Sits between the ROM/fetch logic and the instruction register, and drives that register's ena/data inputs directly.

Parameters:
- DEPTH, 2, word FIFO depth; power of two, minimum 2.
- GAP_CYCLES, 1, idle cycles inserted after every byte strobe; range 0..7.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- word_valid  input  1  producer has a word on word_in
- word_ready  output  1  FIFO can accept a word
- word_in  input  16  instruction word, [15:8] sent first
- ena  output  1  one-cycle byte strobe to the instruction register
- data  output  8  byte being delivered
- busy  output  1  FSM not in IDLE, or FIFO non-empty
- done  output  1  one-cycle pulse, coincident with the low-byte strobe

Behaviour:
- Reset (asynchronous, any state):
  - FIFO emptied; FSM to IDLE.
  - ena=0, data=8'h00, done=0, busy=0, word_ready=1.
  - A word partially sent when reset asserts is discarded; nothing resumes after release.
- Push rule:
  - Push on clk rising edge when word_valid && word_ready.
  - word_ready = !full, registered from FIFO count.
  - No bypass: when full, a same-cycle pop does not allow a push that cycle.
  - word_valid while !word_ready is ignored; the producer must hold its word.
- FSM states: IDLE, HI, GAP_H, LO, GAP_L.
- IDLE:
  - If FIFO non-empty → HI. Pop the head into the 16-bit shadow register on that edge.
- HI (1 cycle): ena=1, data=shadow[15:8].
  - GAP_CYCLES>0 → GAP_H; else → LO.
- GAP_H (GAP_CYCLES cycles): ena=0; data holds the high byte.
  - After the last gap cycle → LO.
- LO (1 cycle): ena=1, data=shadow[7:0], done=1.
  - GAP_CYCLES>0 → GAP_L.
  - Else, if FIFO non-empty → HI with pop; else → IDLE.
- GAP_L (GAP_CYCLES cycles): ena=0; data holds the low byte.
  - After the last gap cycle: if FIFO non-empty → HI with pop; else → IDLE.
- Gap counter: 3 bits; loaded with GAP_CYCLES-1 on entry to a gap state; exits at 0.
- Latency: word accepted at edge N (FSM in IDLE, FIFO empty) → HI strobe in cycle N+1.
- Throughput: one word per 2+2*GAP_CYCLES cycles. Default: 4 cycles per word.
- All outputs are registered; data changes only on entry to HI or LO.
- A push and a pop in the same cycle (not full) leave the count unchanged, and both complete.
- FIFO pointers wrap modulo DEPTH; the count is log2(DEPTH)+1 bits wide.
- busy = (state!=IDLE) || (count!=0).

Optional Feature:
- Macro: FETCH_BYTE_SERVER_STATS_EN.
- With it defined:
  - Extra output word_cnt[15:0] counts completed words (done pulses).
  - Extra output ovf_cnt[7:0] counts cycles with word_valid && !word_ready.
  - Both counters saturate at all-ones and clear on reset.
- Without it: neither port nor the counter logic exists.

Decomposition:
- Package fetch_ser_pkg holds:
  - fsm_state_e enum (IDLE, HI, GAP_H, LO, GAP_L).
  - Constants: WORD_W=16, BYTE_W=8, GAP_CNT_W=3.
- Sub-module word_fifo: synchronous FIFO with parameters DEPTH and WIDTH.
  - Ports: push, pop, wdata, rdata, full, empty, count.
  - Asynchronous active-high reset.
  - Instantiated once.

Test Plan:
- Reset mid-word: push 16'hA5C3, assert reset while in GAP_H → ena=0, data=8'h00, word_ready=1 immediately. No LO strobe after release.
- Single word, GAP_CYCLES=1: push 16'h1234 at edge N.
  - ena in cycles N+1 (data 8'h12) and N+3 (data 8'h34).
  - done in N+3; busy falls at N+5.
- Back-to-back, GAP_CYCLES=0: push 16'hE001, 16'h2FFE, 16'h7ABC continuously.
  - ena stays high for 6 consecutive cycles with bytes E0,01,2F,FE,7A,BC.
  - done on cycles 2, 4, 6.
- Backpressure, DEPTH=2, GAP_CYCLES=1: hold word_valid with 4 words.
  - word_ready drops after the FIFO fills.
  - All 4 words arrive in order, none lost or duplicated.
- Max gap, GAP_CYCLES=7: push 16'hFF00 → exactly 7 ena=0 cycles between the FF and 00 strobes; data held at 8'hFF throughout.
- STATS_EN build: 3 words plus 5 cycles of stalled word_valid → word_cnt=3, ovf_cnt=5. Forced saturation holds at 16'hFFFF.
